// File: rtl/mux8way_rr_if.sv
// Handshake bundle for the 8-way round-robin fan-in mux: eight request channels in,
// one tagged output stream out.
interface mux8way_rr_if #(
    parameter int unsigned WIDTH = 8
);
    logic [7:0]         in_valid;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_ready;

    // Mux side of the bundle.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        input  out_ready
    );

    // Source/sink side of the bundle.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        output out_ready
    );
endinterface

// File: rtl/mux8way_rr.sv
// 8-to-1 round-robin fan-in with a single registered output stage; each word is tagged with
// its source channel index so a downstream demux can route responses back.
module mux8way_rr #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    mux8way_rr_if.slave  bus
);
    typedef enum logic {StEmpty, StFull} state_e;

    state_e             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [2:0]         sel_q, sel_d;

    logic               found;
    logic [2:0]         grant;
    logic [2:0]         idx;
    logic               can_load;
    logic               load;

    // First requesting channel at or after ptr_q, wrapping through 3-bit overflow.
    always_comb begin
        found = 1'b0;
        grant = ptr_q;
        idx   = '0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign can_load = (state_q == StEmpty) || bus.out_ready;
    assign load     = found && can_load && !reset;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;

        unique case (state_q)
            StEmpty: if (load) state_d = StFull;
            StFull:  if (bus.out_ready && !load) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase

        if (load) begin
            sel_d = grant;
            ptr_d = grant + 3'd1;
            for (int i = 0; i < 8; i++) begin
                if (grant == 3'(i)) data_d = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.in_ready  = load ? (8'b1 << grant) : 8'b0;
    assign bus.out_valid = (state_q == StFull);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_mux8way_rr.sv
// Scoreboard bench for mux8way_rr: a cycle-level reference model predicts grants and pushes
// expected words; a monitor pops and compares on every output handshake.
module tb_mux8way_rr;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [2:0]   sel;
        logic [W-1:0] data;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux8way_rr_if #(.WIDTH(W)) bus ();
    mux8way_rr #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    item_t sb_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    m_ptr = 0;
    bit    m_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8*W-1:0] ramp(input logic [W-1:0] base);
        logic [8*W-1:0] d;
        for (int i = 0; i < 8; i++) d[i*W +: W] = base + W'(i);
        return d;
    endfunction

    // One clock: apply inputs, predict at negedge, then advance the model past the posedge.
    task automatic cycle(input logic rst, input logic [7:0] v, input logic [8*W-1:0] d,
                         input logic ordy);
        int         g;
        int         c;
        logic [7:0] exp_rdy;
        reset         = rst;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(negedge clk);
        g = -1;
        exp_rdy = 8'b0;
        if (!rst && (!m_full || ordy)) begin
            for (int k = 0; k < 8; k++) begin
                c = (m_ptr + k) % 8;
                if (g < 0 && v[c]) g = c;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (!rst) chk("out_valid", 32'(bus.out_valid), 32'(m_full));
        if (rst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            sb_q.delete();
        end else if (g >= 0) begin
            sb_q.push_back('{sel: 3'(g), data: d[g*W +: W]});
            m_full = 1'b1;
            m_ptr  = (g + 1) % 8;
        end else if (ordy) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output word must match the oldest predicted word.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out: got sel %0d data %0h, expected no word",
                         bus.out_sel, bus.out_data);
            end else begin
                item_t e;
                e = sb_q.pop_front();
                chk("out_sel", 32'(bus.out_sel), 32'(e.sel));
                chk("out_data", 32'(bus.out_data), 32'(e.data));
            end
        end
    end

    initial begin
        logic [8*W-1:0] d;
        logic [7:0]     v;

        // Reset held with every channel requesting.
        cycle(1'b1, 8'hFF, ramp(8'h00), 1'b1);
        cycle(1'b1, 8'hFF, ramp(8'h00), 1'b1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_sel", 32'(bus.out_sel), 32'd0);

        // Single request on channel 5, then all channels from ptr=6.
        d = '0;
        d[5*W +: W] = 8'h55;
        cycle(1'b0, 8'b0010_0000, d, 1'b1);
        chk("ch5_sel", 32'(bus.out_sel), 32'd5);
        chk("ch5_data", 32'(bus.out_data), 32'h55);
        cycle(1'b0, 8'hFF, ramp(8'h10), 1'b1);
        chk("after_ch5_sel", 32'(bus.out_sel), 32'd6);

        // Full rotation from ptr=0.
        cycle(1'b1, 8'h00, '0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 8'hFF, ramp(8'h10), 1'b1);
            chk("rotate_sel", 32'(bus.out_sel), 32'(i % 8));
        end

        // Stall holding channel 2's word, then release.
        cycle(1'b1, 8'h00, '0, 1'b1);
        d = '0;
        d[2*W +: W] = 8'hA2;
        cycle(1'b0, 8'b0000_0100, d, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'hFF, ramp(8'hB0), 1'b0);
            chk("stall_data", 32'(bus.out_data), 32'hA2);
            chk("stall_sel", 32'(bus.out_sel), 32'd2);
        end
        cycle(1'b0, 8'hFF, ramp(8'hB0), 1'b1);
        chk("unstall_sel", 32'(bus.out_sel), 32'd3);

        // Pointer wrap 7 -> 0.
        cycle(1'b1, 8'h00, '0, 1'b1);
        cycle(1'b0, 8'b0100_0000, ramp(8'h60), 1'b1);
        cycle(1'b0, 8'b1000_0010, ramp(8'h70), 1'b1);
        chk("wrap_first", 32'(bus.out_sel), 32'd7);
        cycle(1'b0, 8'b1000_0010, ramp(8'h70), 1'b1);
        chk("wrap_second", 32'(bus.out_sel), 32'd1);

        // Reset while a word is stalled.
        cycle(1'b0, 8'b0001_0000, ramp(8'hC0), 1'b0);
        cycle(1'b0, 8'h00, '0, 1'b0);
        cycle(1'b1, 8'h00, '0, 1'b0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 8'b1000_0001, ramp(8'hD0), 1'b1);
        chk("midrst_grant", 32'(bus.out_sel), 32'd0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            v = 8'($urandom) & 8'($urandom);
            for (int i = 0; i < 8; i++) d[i*W +: W] = W'($urandom);
            cycle(($urandom_range(0, 99) == 0), v, d, ($urandom_range(0, 3) != 0));
        end

        // Drain; nothing predicted may be left unseen.
        cycle(1'b0, 8'h00, '0, 1'b1);
        cycle(1'b0, 8'h00, '0, 1'b1);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
